poll_scheduler: RTL and testbench
=================================

# poll_scheduler

Hardware poll sequencer between the CPU's I/O read port and up to N_DEV polled input devices that use the status/data/ack protocol: `a0`=1 selects status, `a0`=0 selects data, and `ack` with `a0`=0 clears status. The block scans the devices, reads data from each device whose status bit0 is set, acknowledges it, and queues the word in a FIFO tagged with the device index. The CPU then services one queue through the same two-word protocol instead of polling each device itself.

## Interface
- N_DEV, 4: number of devices; 2..16.
- FIFO_DEPTH, 4: queue entries; power of two, 2..32.
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- dev_a0  out  N_DEV  per-device address select; 1 = status word, 0 = data word.
- dev_ack  out  N_DEV  per-device one-cycle acknowledge.
- dev_data  in  16*N_DEV  device words, combinational in dev_a0; device i occupies bits [16i+15:16i].
- cpu_a0  in  1  1 = read queue status, 0 = read queue head data.
- cpu_rd  in  1  read strobe; pops the queue when cpu_a0=0.
- cpu_data  out  16  word selected by cpu_a0.

## Operation
- State: idx (current device), FSM {S_STATUS, S_DATA}, FIFO of {id, data[15:0]}, count.
- S_STATUS:
  - Drive dev_a0[idx]=1; all other dev_a0 and dev_ack bits are 0.
  - If dev_data[idx] bit0=1 and FIFO is not full, go to S_DATA.
  - Otherwise advance idx and stay in S_STATUS.
- S_DATA:
  - Drive dev_a0[idx]=0 and dev_ack[idx]=1.
  - Push {idx, dev_data[idx]} at the edge, advance idx, return to S_STATUS.
- idx advance: (idx+1) mod N_DEV.
- FIFO full at status check: the device is skipped and not acked. Its event stays pending in the device, so nothing is lost.
- A push is always legal. Only S_DATA pushes, and fullness was checked in the preceding cycle.
- cpu_a0=1 returns {head_id[7:0], count[5:0], full, nonempty}, with head_id and count zero-extended. head_id reads 0 when the FIFO is empty.
- cpu_a0=0 returns head data, or 0x0000 when the FIFO is empty.
- Pop occurs when cpu_rd && !cpu_a0 && nonempty. A pop on an empty FIFO is ignored.
- Push and pop in the same cycle: count is unchanged, and head and tail pointers both advance.
- Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset:
  - idx=0, state S_STATUS, FIFO empty, count=0.
  - After reset: dev_a0=one-hot bit 0, dev_ack=0, cpu_data=0x0000 for both cpu_a0 values.
- dev_ack is forced to 0 while reset=1. Reset asserted in S_DATA therefore does not ack; the device event remains pending and no push occurs.
- Device visit cost: 1 cycle with no event, 2 cycles when servicing.
- An entry is visible on cpu_data the cycle after the S_DATA edge.
- Worst-case service latency for a pending event with FIFO space: 2*N_DEV cycles (round-robin).
- A pop takes effect at the edge; the next head is visible the following cycle.

## Configuration
- POLL_SCHED_PRIORITY_EN defined: fixed priority. After any S_DATA, idx returns to 0, so lower index wins. After an S_STATUS with no service, idx advances normally.
- POLL_SCHED_PRIORITY_EN undefined: round-robin as described under Operation.

## Test plan
All scenarios use N_DEV=4, FIFO_DEPTH=4.
- Reset: hold reset 2 cycles. Require dev_a0=4'b0001, dev_ack=0, cpu_data=0x0000 with cpu_a0=0 and with cpu_a0=1.
- Single event: device 2 raises status with data 0x0001.
  - dev_ack[2] is high exactly one cycle.
  - Status read returns 0x0205.
  - Data read returns 0x0001.
  - cpu_rd with cpu_a0=0 pops; status then returns 0x0000.
- Full and back-pressure: devices 0-3 each queue one event with no pops, giving status 0x0013.
  - Then a new event on device 0 is not acked while full.
  - After one pop, device 0 is acked and count returns to 4.
- Fairness: all four devices always pending, CPU pops every other cycle.
  - Round-robin build: queued ids are 0,1,2,3,0,1,...
  - With POLL_SCHED_PRIORITY_EN: id 0 dominates whenever device 0 is pending.
- Boundaries:
  - Pop on empty leaves status 0x0000.
  - Pop in the same cycle as an S_DATA push at count=2 leaves count=2, and the head advances to the next entry.
- Reset mid-service: assert reset during S_DATA for device 1.
  - dev_ack[1] stays 0 and no push occurs.
  - After reset, device 1 is serviced with its original data.

Source files
------------

// File: rtl/poll_scheduler_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | poll_scheduler_if : device poll bus plus CPU queue read port              |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface poll_scheduler_if #(
  parameter int N_DEV = 4
);
  logic [N_DEV-1:0]    dev_a0;
  logic [N_DEV-1:0]    dev_ack;
  logic [16*N_DEV-1:0] dev_data;
  logic                cpu_a0;
  logic                cpu_rd;
  logic [15:0]         cpu_data;

  // master is the scheduler, slave is the device/CPU side
  modport master (
    output dev_a0, dev_ack, cpu_data,
    input  dev_data, cpu_a0, cpu_rd
  );
  modport slave (
    input  dev_a0, dev_ack, cpu_data,
    output dev_data, cpu_a0, cpu_rd
  );
endinterface
`default_nettype wire

// File: rtl/poll_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | poll_scheduler : scans status/data devices, queues {id,data} for the CPU  |
// | Option macro POLL_SCHED_PRIORITY_EN: fixed priority (idx 0 after service) |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module poll_scheduler #(
  parameter int N_DEV      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  poll_scheduler_if.master  bus
);
  localparam int IDX_W = $clog2(N_DEV);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DEV - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    S_STATUS = 1'b0,
    S_DATA   = 1'b1
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] fifo_id   [FIFO_DEPTH];
  logic [15:0]      fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic [15:0]      dev_word [N_DEV];
  logic [15:0]      cur_word;
  logic [IDX_W-1:0] next_idx;
  logic [N_DEV-1:0] sel;
  logic             full;
  logic             nonempty;
  logic             push;
  logic             pop;
  logic [IDX_W-1:0] head_id;
  logic [15:0]      head_data;
  logic [15:0]      status_word;

  generate
    for (genvar g = 0; g < N_DEV; g++) begin : g_dev_word
      assign dev_word[g] = bus.dev_data[16*g +: 16];
    end
  endgenerate

  assign cur_word = dev_word[idx];
  assign next_idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
  assign sel      = {{(N_DEV-1){1'b0}}, 1'b1} << idx;
  assign full     = (count == FULL_CNT);
  assign nonempty = (count != '0);
  assign push     = (state == S_DATA);
  assign pop      = bus.cpu_rd && !bus.cpu_a0 && nonempty;

  assign bus.dev_a0  = (state == S_STATUS) ? sel : '0;
  // Gated by reset so an interrupted service leaves the device event pending
  assign bus.dev_ack = (state == S_DATA && !reset) ? sel : '0;

  assign head_id     = nonempty ? fifo_id[head]   : '0;
  assign head_data   = nonempty ? fifo_data[head] : 16'h0000;
  assign status_word = {8'(head_id), 6'(count), full, nonempty};
  assign bus.cpu_data = bus.cpu_a0 ? status_word : head_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_STATUS;
      idx   <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      case (state)
        S_STATUS: begin
          if (cur_word[0] && !full) begin
            state <= S_DATA;
          end else begin
            idx <= next_idx;
          end
        end
        S_DATA: begin
          // Fullness was checked in the status cycle, so this push always fits
          fifo_id[tail]   <= idx;
          fifo_data[tail] <= cur_word;
          tail            <= tail + 1'b1;
`ifdef POLL_SCHED_PRIORITY_EN
          idx             <= '0;
`else
          idx             <= next_idx;
`endif
          state           <= S_STATUS;
        end
        default: state <= S_STATUS;
      endcase

      if (pop) begin
        head <= head + 1'b1;
      end

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_poll_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_poll_scheduler : directed scenarios with an ack/pop scoreboard monitor |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_poll_scheduler;
  localparam int N = 4;

  typedef struct packed {
    logic [3:0]  id;
    logic [15:0] data;
  } rec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  poll_scheduler_if #(.N_DEV(N)) bus ();

  poll_scheduler #(.N_DEV(N), .FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Device models: status bit0 = pending, cleared by ack with a0=0
  logic [N-1:0] pending  = '0;
  logic [N-1:0] set_pend = '0;
  logic [N-1:0] clr_pend = '0;
  logic [N-1:0] rearm    = '0;
  logic [15:0]  dat [N];

  generate
    for (genvar g = 0; g < N; g++) begin : g_dev
      assign bus.dev_data[16*g +: 16] = bus.dev_a0[g] ? {15'd0, pending[g]} : dat[g];
    end
  endgenerate

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (clr_pend[i])                          pending[i] <= 1'b0;
      else if (set_pend[i])                     pending[i] <= 1'b1;
      else if (bus.dev_ack[i] && !bus.dev_a0[i]) pending[i] <= rearm[i];
    end
  end

  int          checks = 0;
  int          errors = 0;
  int          ack_cnt [N];
  int          avail = 0;
  rec_t        exp_ack [$];
  logic [15:0] exp_rd  [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Monitor: pops expected acks and CPU reads as the DUT presents them
  always @(negedge clk) begin
    if (reset) begin
      exp_rd.delete();
      avail = 0;
    end else begin
      if (bus.cpu_rd && !bus.cpu_a0) begin
        if (avail > 0) begin
          check("pop_data", bus.cpu_data, exp_rd.pop_front());
          avail--;
        end else begin
          check("pop_empty_data", bus.cpu_data, 16'h0000);
        end
      end
      if (bus.dev_ack != '0) begin
        check("ack_onehot", $countones(bus.dev_ack), 1);
        for (int i = 0; i < N; i++) begin
          if (bus.dev_ack[i]) begin
            rec_t r;
            logic [15:0] w;
            ack_cnt[i]++;
            w = bus.dev_data[16*i +: 16];
            if (exp_ack.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_ack: actual=dev%0d required=none", i);
            end else begin
              r = exp_ack.pop_front();
              check("ack_id", i, r.id);
              check("ack_data", w, r.data);
              exp_rd.push_back(r.data);
              avail++;
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_reset();
    reset      = 1'b1;
    bus.cpu_rd = 1'b0;
    bus.cpu_a0 = 1'b1;
    set_pend   = '0;
    rearm      = '0;
    clr_pend   = '1;
    tick();
    clr_pend   = '0;
    tick();
  endtask

  task automatic release_with(input logic [N-1:0] pend);
    set_pend = pend;
    tick();
    set_pend = '0;
    reset    = 1'b0;
  endtask

  task automatic drain_acks(input string name, input int budget);
    int n = 0;
    while (exp_ack.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_ack.size() != 0) begin
      expire(name);
      exp_ack.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int base;
    rec_t r;
    for (int i = 0; i < N; i++) begin
      ack_cnt[i] = 0;
      dat[i]     = 16'h0000;
    end
    bus.cpu_a0 = 1'b1;
    bus.cpu_rd = 1'b0;

    // Reset state
    start_reset();
    release_with('0);
    check("reset_dev_a0", bus.dev_a0, 4'b0001);
    check("reset_dev_ack", bus.dev_ack, 4'b0000);
    check("reset_status", bus.cpu_data, 16'h0000);
    bus.cpu_a0 = 1'b0; #1;
    check("reset_data", bus.cpu_data, 16'h0000);

    // Single event on device 2
    dat[2] = 16'h0001;
    start_reset();
    exp_ack.push_back({4'd2, 16'h0001});
    base = ack_cnt[2];
    release_with(4'b0100);
    n = 0;
    while (!bus.cpu_data[0] && n < 30) begin tick(); n++; end
    if (!bus.cpu_data[0]) expire("single_wait");
    check("single_status", bus.cpu_data, 16'h0205);
    repeat (3) tick();
    check("single_ack_once", ack_cnt[2] - base, 1);
    bus.cpu_a0 = 1'b0; #1;
    check("single_data", bus.cpu_data, 16'h0001);
    bus.cpu_rd = 1'b1;
    tick();
    bus.cpu_rd = 1'b0;
    bus.cpu_a0 = 1'b1; #1;
    check("single_after_pop", bus.cpu_data, 16'h0000);

    // Full queue and back-pressure
    for (int i = 0; i < N; i++) dat[i] = 16'hA000 + 16'(i);
    start_reset();
    for (int i = 0; i < N; i++) exp_ack.push_back({4'(i), 16'hA000 + 16'(i)});
    release_with(4'b1111);
    n = 0;
    while (!bus.cpu_data[1] && n < 30) begin tick(); n++; end
    if (!bus.cpu_data[1]) expire("full_wait");
    check("full_status", bus.cpu_data, 16'h0013);
    base = ack_cnt[0];
    dat[0] = 16'hB000;
    exp_ack.push_back({4'd0, 16'hB000});
    set_pend = 4'b0001;
    tick();
    set_pend = '0;
    repeat (10) tick();
    check("full_no_ack", ack_cnt[0] - base, 0);
    check("full_status_hold", bus.cpu_data, 16'h0013);
    bus.cpu_a0 = 1'b0; #1;
    check("full_head", bus.cpu_data, 16'hA000);
    bus.cpu_rd = 1'b1;
    tick();
    bus.cpu_rd = 1'b0;
    bus.cpu_a0 = 1'b1;
    n = 0;
    while (ack_cnt[0] == base && n < 20) begin tick(); n++; end
    if (ack_cnt[0] == base) expire("full_refill_wait");
    tick();
    check("full_refill_status", bus.cpu_data, 16'h0113);

    // Fairness with every device always pending
    for (int i = 0; i < N; i++) dat[i] = 16'hC000 + 16'(i);
    start_reset();
    rearm = '1;
    for (int k = 0; k < 12; k++) begin
`ifdef POLL_SCHED_PRIORITY_EN
      r.id = 4'd0;
`else
      r.id = 4'(k % N);
`endif
      r.data = 16'hC000 + 16'(r.id);
      exp_ack.push_back(r);
    end
    release_with(4'b1111);
    bus.cpu_a0 = 1'b0;
    n = 0;
    while (exp_ack.size() != 0 && n < 200) begin
      bus.cpu_rd = ~bus.cpu_rd;
      tick();
      n++;
    end
    if (exp_ack.size() != 0) begin
      expire("fair_wait");
      exp_ack.delete();
    end

    // Pop on empty
    start_reset();
    release_with('0);
    bus.cpu_a0 = 1'b0;
    bus.cpu_rd = 1'b1;
    tick();
    bus.cpu_rd = 1'b0;
    bus.cpu_a0 = 1'b1; #1;
    check("empty_pop_status", bus.cpu_data, 16'h0000);

    // Pop coinciding with a push at count=2
    for (int i = 0; i < 3; i++) dat[i] = 16'hD000 + 16'(i);
    start_reset();
    for (int i = 0; i < 3; i++) exp_ack.push_back({4'(i), 16'hD000 + 16'(i)});
    release_with(4'b0111);
    n = 0;
    while (!bus.dev_ack[2] && n < 30) begin tick(); n++; end
    if (!bus.dev_ack[2]) expire("pp_wait");
    check("pp_status_before", bus.cpu_data, 16'h0009);
    bus.cpu_a0 = 1'b0;
    bus.cpu_rd = 1'b1; #1;
    tick();
    bus.cpu_rd = 1'b0;
    bus.cpu_a0 = 1'b1; #1;
    check("pp_status_after", bus.cpu_data, 16'h0109);
    bus.cpu_a0 = 1'b0; #1;
    check("pp_head", bus.cpu_data, 16'hD001);

    // Reset asserted during service of device 1
    dat[1] = 16'h5A51;
    start_reset();
    exp_ack.push_back({4'd1, 16'h5A51});
    release_with(4'b0010);
    n = 0;
    while (bus.dev_a0 != '0 && n < 30) begin tick(); n++; end
    if (bus.dev_a0 != '0) expire("rms_wait");
    base = ack_cnt[1];
    reset = 1'b1; #1;
    check("rms_ack_forced_low", bus.dev_ack, 4'b0000);
    tick();
    tick();
    check("rms_no_ack", ack_cnt[1] - base, 0);
    bus.cpu_a0 = 1'b1; #1;
    check("rms_status_in_reset", bus.cpu_data, 16'h0000);
    reset = 1'b0;
    drain_acks("rms_service_wait", 30);
    check("rms_status", bus.cpu_data, 16'h0105);
    bus.cpu_a0 = 1'b0; #1;
    check("rms_data", bus.cpu_data, 16'h5A51);

    tick();
    check("ack_queue_empty", exp_ack.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
